// File: rtl/tone_pkg.sv
// -----------------------------------------------------------------------------
// tone_pkg
// Shared definitions for the audible-signal tone scheduler:
//   - scheduler state encoding (IDLE / ON / OFF)
//   - requester bit positions within req / grant
//   - cadence phase lengths in ticks
//   - tone frequencies in Hz
//   - div_of(): elaboration-time divisor helper
//   - on_len_of() / off_len_of(): phase length lookup by one-hot grant
// -----------------------------------------------------------------------------
package tone_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_e;

    // Requester bit positions; higher index means higher priority.
    localparam int unsigned REQ_WALK  = 0;
    localparam int unsigned REQ_WARN  = 1;
    localparam int unsigned REQ_SIREN = 2;

    localparam logic [2:0] GNT_NONE  = 3'b000;
    localparam logic [2:0] GNT_WALK  = 3'b001;
    localparam logic [2:0] GNT_WARN  = 3'b010;
    localparam logic [2:0] GNT_SIREN = 3'b100;

    // Cadence phase lengths, in ticks.
    localparam logic [9:0] WALK_ON_TICKS   = 10'd50;
    localparam logic [9:0] WALK_OFF_TICKS  = 10'd950;
    localparam logic [9:0] WARN_ON_TICKS   = 10'd250;
    localparam logic [9:0] WARN_OFF_TICKS  = 10'd250;
    localparam logic [9:0] SIREN_PH_TICKS  = 10'd500;

    // Tone frequencies, in Hz.
    localparam int unsigned F_440 = 440;
    localparam int unsigned F_660 = 660;
    localparam int unsigned F_880 = 880;

    // Only ever evaluated on constants, so the division happens at elaboration.
    function automatic int unsigned div_of(input int unsigned clk_hz,
                                           input int unsigned f);
        return clk_hz / f;
    endfunction

    function automatic logic [9:0] on_len_of(input logic [2:0] gnt);
        logic [9:0] len;
        len = '0;
        case (gnt)
            GNT_SIREN: len = SIREN_PH_TICKS;
            GNT_WARN:  len = WARN_ON_TICKS;
            GNT_WALK:  len = WALK_ON_TICKS;
            default:   len = '0;
        endcase
        return len;
    endfunction

    function automatic logic [9:0] off_len_of(input logic [2:0] gnt);
        logic [9:0] len;
        len = '0;
        case (gnt)
            GNT_WARN: len = WARN_OFF_TICKS;
            GNT_WALK: len = WALK_OFF_TICKS;
            default:  len = '0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Free-running divider producing a one-cycle tick every DIV clock cycles.
// The counter runs 0 .. DIV-1 and the tick is high on the wrap cycle, so after
// reset the first tick is on cycle DIV (1-based).
//   clk    in   system clock
//   reset  in   synchronous, active-high reset (clears the counter)
//   tick   out  1-cycle pulse every DIV cycles
// -----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int unsigned DIV = 12000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/tone_scheduler.sv
// -----------------------------------------------------------------------------
// tone_scheduler
// Time-shares one tone generator between the walk chirp, the don't-walk
// warning and the emergency siren. Fixed priority siren > warning > walk,
// cadence sequenced on a millisecond tick, outputs all registered.
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   req[2:0]  in   level requests: [2] siren, [1] warning, [0] walk
//   grant     out  one-hot granted requester, 0 when idle
//   tone_en   out  generator enable, high only during an ON phase
//   tone_div  out  CLK_HZ / f toggle divisor, 0 when tone_en is low
// -----------------------------------------------------------------------------
module tone_scheduler
    import tone_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 12_000_000,
    parameter int unsigned TICK_HZ = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    output logic [2:0]  grant,
    output logic        tone_en,
    output logic [23:0] tone_div
);

    localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;

    localparam logic [23:0] DIV_440 = 24'(div_of(CLK_HZ, F_440));
    localparam logic [23:0] DIV_660 = 24'(div_of(CLK_HZ, F_660));
    localparam logic [23:0] DIV_880 = 24'(div_of(CLK_HZ, F_880));

    logic tick;

    tick_prescaler #(
        .DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    state_e      state_q, state_d;
    logic [2:0]  grant_q, grant_d;
    logic [9:0]  cnt_q, cnt_d;
    logic        sub_q, sub_d;      // siren sub-phase: 0 = 660 Hz, 1 = 880 Hz
    logic        tone_en_q, tone_en_d;
    logic [23:0] tone_div_q, tone_div_d;

    logic [2:0]  winner;
    logic        phase_end;
    logic        preempt;

    // Highest-priority active request, one-hot.
    always_comb begin
        winner = GNT_NONE;
        if (req[REQ_SIREN]) begin
            winner = GNT_SIREN;
        end else if (req[REQ_WARN]) begin
            winner = GNT_WARN;
        end else if (req[REQ_WALK]) begin
            winner = GNT_WALK;
        end
    end

    // One-hot encodings order by priority, so a numeric compare is a
    // priority compare.
    assign preempt   = (winner > grant_q);
    // Counter would reach 0 on this tick.
    assign phase_end = (cnt_q <= 10'd1);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        sub_d   = sub_q;

        case (state_q)
            IDLE: begin
                if (winner != GNT_NONE) begin
                    state_d = ON;
                    grant_d = winner;
                    cnt_d   = on_len_of(winner);
                    sub_d   = 1'b0;
                end
            end

            ON, OFF: begin
                if (tick) begin
                    if (preempt || (phase_end && winner != grant_q && winner != GNT_NONE)) begin
                        // New owner always starts fresh in ON; siren at 660 Hz.
                        state_d = ON;
                        grant_d = winner;
                        cnt_d   = on_len_of(winner);
                        sub_d   = 1'b0;
                    end else if (phase_end) begin
                        if (winner == GNT_NONE) begin
                            state_d = IDLE;
                            grant_d = GNT_NONE;
                            cnt_d   = '0;
                            sub_d   = 1'b0;
                        end else if (grant_q == GNT_SIREN) begin
                            state_d = ON;
                            cnt_d   = SIREN_PH_TICKS;
                            sub_d   = ~sub_q;
                        end else if (state_q == ON) begin
                            state_d = OFF;
                            cnt_d   = off_len_of(grant_q);
                        end else begin
                            state_d = ON;
                            cnt_d   = on_len_of(grant_q);
                        end
                    end else begin
                        cnt_d = cnt_q - 10'd1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = GNT_NONE;
                cnt_d   = '0;
                sub_d   = 1'b0;
            end
        endcase
    end

    // Outputs are derived from next state so they register alongside it.
    always_comb begin
        tone_en_d  = (state_d == ON);
        tone_div_d = '0;
        if (state_d == ON) begin
            case (grant_d)
                GNT_SIREN: tone_div_d = sub_d ? DIV_880 : DIV_660;
                GNT_WARN:  tone_div_d = DIV_440;
                GNT_WALK:  tone_div_d = DIV_880;
                default:   tone_div_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= GNT_NONE;
            cnt_q      <= '0;
            sub_q      <= 1'b0;
            tone_en_q  <= 1'b0;
            tone_div_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            sub_q      <= sub_d;
            tone_en_q  <= tone_en_d;
            tone_div_q <= tone_div_d;
        end
    end

    assign grant    = grant_q;
    assign tone_en  = tone_en_q;
    assign tone_div = tone_div_q;

endmodule

// File: tb/tb_tone_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tone_scheduler
// Self-checking bench for tone_scheduler. Each scenario task drives req,
// queues the expected outputs at absolute cycle numbers (counted from the last
// reset edge), then pops and compares them as the DUT reaches those cycles.
// -----------------------------------------------------------------------------
module tb_tone_scheduler;

    localparam int unsigned CLK_HZ  = 120_000;
    localparam int unsigned TICK_HZ = 12_000;
    localparam int unsigned T       = CLK_HZ / TICK_HZ;   // cycles per tick

    localparam logic [23:0] D880 = 24'd136;   // 120000 / 880
    localparam logic [23:0] D660 = 24'd181;   // 120000 / 660
    localparam logic [23:0] D440 = 24'd272;   // 120000 / 440

    logic        clk;
    logic        reset;
    logic [2:0]  req;
    logic [2:0]  grant;
    logic        tone_en;
    logic [23:0] tone_div;

    tone_scheduler #(
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(TICK_HZ)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .grant   (grant),
        .tone_en (tone_en),
        .tone_div(tone_div)
    );

    typedef struct {
        string       name;
        int unsigned at;
        logic [2:0]  g;
        logic        en;
        logic [23:0] div;
    } exp_t;

    exp_t        sb[$];
    int unsigned tests;
    int unsigned fails;
    int unsigned pe;        // posedges since the last reset edge
    logic        watch;
    int unsigned en_zero;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) pe <= 0;
        else       pe <= pe + 1;
    end

    always @(negedge clk) begin
        if (watch && tone_en !== 1'b1) en_zero = en_zero + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got pe=%0d required completion", pe);
        $fatal(1);
    end

    task automatic expect_at(input string n, input int unsigned at,
                             input logic [2:0] g, input logic en, input logic [23:0] div);
        exp_t e;
        e.name = n; e.at = at; e.g = g; e.en = en; e.div = div;
        sb.push_back(e);
    endtask

    task automatic wait_pe(input int unsigned n);
        while (pe < n) @(negedge clk);
    endtask

    // Leaves the bench at the negedge after the last reset edge (pe = 0),
    // with reset released and req driven.
    task automatic do_reset(input logic [2:0] r);
        @(negedge clk);
        reset = 1'b1;
        req   = 3'b000;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        req   = r;
    endtask

    task automatic test_reset();
        exp_t e;
        do_reset(3'b000);
        expect_at("reset_state", 0, 3'b000, 1'b0, 24'd0);
        expect_at("idle_no_req", 5, 3'b000, 1'b0, 24'd0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            while (pe < e.at) @(negedge clk);
            tests++;
            if (pe !== e.at || grant !== e.g || tone_en !== e.en || tone_div !== e.div) begin
                fails++;
                $display("FAIL %s @%0d: got grant=%b en=%b div=%0d, required grant=%b en=%b div=%0d (at %0d)",
                         e.name, pe, grant, tone_en, tone_div, e.g, e.en, e.div, e.at);
            end
        end
    endtask

    task automatic test_walk();
        exp_t e;
        do_reset(3'b001);
        expect_at("walk_start",      1,                       3'b001, 1'b1, D880);
        expect_at("walk_on_last",    50*T - 1,                3'b001, 1'b1, D880);
        expect_at("walk_off_first",  50*T,                    3'b001, 1'b0, 24'd0);
        expect_at("walk_off_last",   1000*T - 1,              3'b001, 1'b0, 24'd0);
        expect_at("walk_on2_first",  1000*T,                  3'b001, 1'b1, D880);
        expect_at("walk_on2_last",   1050*T - 1,              3'b001, 1'b1, D880);
        expect_at("walk_off2_first", 1050*T,                  3'b001, 1'b0, 24'd0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            while (pe < e.at) @(negedge clk);
            tests++;
            if (pe !== e.at || grant !== e.g || tone_en !== e.en || tone_div !== e.div) begin
                fails++;
                $display("FAIL %s @%0d: got grant=%b en=%b div=%0d, required grant=%b en=%b div=%0d (at %0d)",
                         e.name, pe, grant, tone_en, tone_div, e.g, e.en, e.div, e.at);
            end
        end
    endtask

    // Warning raised mid walk-ON at cycle 100; next tick is sampled at 11*T.
    task automatic test_preempt();
        exp_t e;
        do_reset(3'b001);
        wait_pe(100);
        req = 3'b011;
        expect_at("pre_hold_walk",  11*T - 1,  3'b001, 1'b1, D880);
        expect_at("pre_warn_on",    11*T,      3'b010, 1'b1, D440);
        expect_at("warn_on_last",   261*T - 1, 3'b010, 1'b1, D440);
        expect_at("warn_off_first", 261*T,     3'b010, 1'b0, 24'd0);
        expect_at("warn_off_last",  511*T - 1, 3'b010, 1'b0, 24'd0);
        expect_at("warn_on2_first", 511*T,     3'b010, 1'b1, D440);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            while (pe < e.at) @(negedge clk);
            tests++;
            if (pe !== e.at || grant !== e.g || tone_en !== e.en || tone_div !== e.div) begin
                fails++;
                $display("FAIL %s @%0d: got grant=%b en=%b div=%0d, required grant=%b en=%b div=%0d (at %0d)",
                         e.name, pe, grant, tone_en, tone_div, e.g, e.en, e.div, e.at);
            end
        end
    endtask

    // Continues from test_preempt: warning ON began at 511*T.
    task automatic test_release();
        exp_t e;
        wait_pe(520*T);
        req = 3'b001;
        expect_at("rel_warn_holds", 761*T - 1, 3'b010, 1'b1, D440);
        expect_at("rel_walk_on",    761*T,     3'b001, 1'b1, D880);
        expect_at("rel_walk_last",  811*T - 1, 3'b001, 1'b1, D880);
        expect_at("rel_walk_off",   811*T,     3'b001, 1'b0, 24'd0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            while (pe < e.at) @(negedge clk);
            tests++;
            if (pe !== e.at || grant !== e.g || tone_en !== e.en || tone_div !== e.div) begin
                fails++;
                $display("FAIL %s @%0d: got grant=%b en=%b div=%0d, required grant=%b en=%b div=%0d (at %0d)",
                         e.name, pe, grant, tone_en, tone_div, e.g, e.en, e.div, e.at);
            end
        end
    endtask

    task automatic test_siren();
        exp_t e;
        do_reset(3'b111);
        expect_at("siren_start", 1, 3'b100, 1'b1, D660);
        for (int unsigned pass = 0; pass < 4; pass++) begin
            if (pass == 1) begin
                watch   = 1'b1;
                en_zero = 0;
                expect_at("siren_660_last",  500*T - 1,  3'b100, 1'b1, D660);
                expect_at("siren_880_first", 500*T,      3'b100, 1'b1, D880);
                expect_at("siren_880_last",  1000*T - 1, 3'b100, 1'b1, D880);
                expect_at("siren_660_again", 1000*T,     3'b100, 1'b1, D660);
            end else if (pass == 2) begin
                wait_pe(1000*T + 100);
                req = 3'b110;
                wait_pe(1000*T + 205);
                req = 3'b111;
                wait_pe(1000*T + 310);
                req = 3'b100;
                expect_at("siren_no_lowpre", 1040*T, 3'b100, 1'b1, D660);
            end else if (pass == 3) begin
                wait_pe(1050*T);
                req = 3'b000;
                expect_at("siren_finishes",  1500*T - 1,  3'b100, 1'b1, D660);
                expect_at("siren_to_idle",   1500*T,      3'b000, 1'b0, 24'd0);
                expect_at("idle_stays",      1505*T,      3'b000, 1'b0, 24'd0);
            end
            while (sb.size() > 0) begin
                e = sb.pop_front();
                while (pe < e.at) @(negedge clk);
                tests++;
                if (pe !== e.at || grant !== e.g || tone_en !== e.en || tone_div !== e.div) begin
                    fails++;
                    $display("FAIL %s @%0d: got grant=%b en=%b div=%0d, required grant=%b en=%b div=%0d (at %0d)",
                             e.name, pe, grant, tone_en, tone_div, e.g, e.en, e.div, e.at);
                end
            end
            if (pass == 1) begin
                watch = 1'b0;
                tests++;
                if (en_zero !== 0) begin
                    fails++;
                    $display("FAIL siren_en_never_low: got %0d cycles with tone_en=0, required 0", en_zero);
                end
            end
        end
    endtask

    // Reset pulsed during walk ON at cycle 200; req stays 001 throughout.
    task automatic test_reset_mid();
        exp_t e;
        do_reset(3'b001);
        for (int unsigned pass = 0; pass < 3; pass++) begin
            if (pass == 0) begin
                expect_at("rm_walk_on", 200, 3'b001, 1'b1, D880);
            end else if (pass == 1) begin
                reset = 1'b1;
                @(negedge clk);
                expect_at("rm_cleared", 0, 3'b000, 1'b0, 24'd0);
            end else begin
                reset = 1'b0;
                expect_at("rm_restart",  1,        3'b001, 1'b1, D880);
                expect_at("rm_on_last",  50*T - 1, 3'b001, 1'b1, D880);
                expect_at("rm_off",      50*T,     3'b001, 1'b0, 24'd0);
            end
            while (sb.size() > 0) begin
                e = sb.pop_front();
                while (pe < e.at) @(negedge clk);
                tests++;
                if (pe !== e.at || grant !== e.g || tone_en !== e.en || tone_div !== e.div) begin
                    fails++;
                    $display("FAIL %s @%0d: got grant=%b en=%b div=%0d, required grant=%b en=%b div=%0d (at %0d)",
                             e.name, pe, grant, tone_en, tone_div, e.g, e.en, e.div, e.at);
                end
            end
        end
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        watch   = 1'b0;
        en_zero = 0;
        reset   = 1'b1;
        req     = 3'b000;
        test_reset();
        test_walk();
        test_preempt();
        test_release();
        test_siren();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
